mci_multi_dom_rst_seqr: RTL and testbench

//  Parametrised N-domain reset/boot sequencer for the MCI subsystem. Releases NUM_DOM reset

---
 rtl/mci_multi_dom_rst_seqr_if.sv | 34 +++
 rtl/mci_multi_dom_rst_seqr.sv | 141 ++++++++++++++
 tb/tb_mci_multi_dom_rst_seqr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mci_multi_dom_rst_seqr_if.sv
// Handshake bundle between the MCI reset sequencer and its reset domains.
// The slave side is the sequencer; the master side drives the domain-facing inputs.
interface mci_multi_dom_rst_seqr_if #(
  parameter int unsigned NUM_DOM = 4
);
  logic               scan_mode;
  logic               seq_go_i;
  logic [NUM_DOM-1:0] dom_go_i;
  logic [NUM_DOM-1:0] dom_rst_req_i;
  logic [NUM_DOM-1:0] dom_halt_ack_i;
  logic [NUM_DOM-1:0] dom_halt_status_i;
  logic [NUM_DOM-1:0] dom_rel_ok_i;
  logic [NUM_DOM-1:0] dom_rst_b_o;
  logic [NUM_DOM-1:0] dom_halt_req_o;
  logic [NUM_DOM-1:0] dom_rdc_clk_dis_o;
  logic [NUM_DOM-1:0] dom_reset_once_o;
  logic [NUM_DOM-1:0] dom_halt_tmo_o;
  logic               boot_done_o;
  logic               busy_o;

  modport master (
    output scan_mode, seq_go_i, dom_go_i, dom_rst_req_i, dom_halt_ack_i,
           dom_halt_status_i, dom_rel_ok_i,
    input  dom_rst_b_o, dom_halt_req_o, dom_rdc_clk_dis_o, dom_reset_once_o,
           dom_halt_tmo_o, boot_done_o, busy_o
  );

  modport slave (
    input  scan_mode, seq_go_i, dom_go_i, dom_rst_req_i, dom_halt_ack_i,
           dom_halt_status_i, dom_rel_ok_i,
    output dom_rst_b_o, dom_halt_req_o, dom_rdc_clk_dis_o, dom_reset_once_o,
           dom_halt_tmo_o, boot_done_o, busy_o
  );
endinterface

// File: rtl/mci_multi_dom_rst_seqr.sv
// N-domain reset/boot sequencer: ordered boot release, then one-at-a-time runtime domain resets
// with halt handshake, halt timeout, RDC clock-disable window and release gating.
module mci_multi_dom_rst_seqr #(
  parameter int unsigned NUM_DOM       = 4,
  parameter int unsigned MIN_RST_CNT_W = 4,
  parameter int unsigned HALT_TMO_W    = 8
) (
  input logic                     clk,
  input logic                     rst,
  mci_multi_dom_rst_seqr_if.slave bus
);
  localparam int unsigned IdxW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StBootWait = 3'd1;
  localparam logic [2:0] StRun      = 3'd2;
  localparam logic [2:0] StHaltReq  = 3'd3;
  localparam logic [2:0] StHaltWait = 3'd4;
  localparam logic [2:0] StRstHold  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d, low_idx;
  logic [MIN_RST_CNT_W-1:0] cnt_q;
  logic [HALT_TMO_W-1:0]    tcnt_q;
  logic [NUM_DOM-1:0]       pending_q, rst_b_q, halt_req_q, once_q, tmo_q, pend_clr;
  logic                     boot_done_q;
  logic                     elapsed, tmo_hit, boot_rel, halt_entry, hold_entry, hold_exit;
  logic                     cnt_clr, in_halt;

  assign elapsed = (cnt_q == '1);
  assign in_halt = (state_q == StHaltReq) || (state_q == StHaltWait);
  assign tmo_hit = in_halt && (tcnt_q == '1);

  // Lowest pending domain wins arbitration.
  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_DOM) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (bus.seq_go_i) begin
          state_d = StBootWait;
          idx_d   = '0;
        end
      end
      StBootWait: begin
        if (elapsed && bus.dom_go_i[idx_q]) begin
          if (idx_q == IdxW'(NUM_DOM - 1)) state_d = StRun;
          else                             idx_d   = idx_q + IdxW'(1);
        end
      end
      StRun: begin
        if (|pending_q) begin
          state_d = StHaltReq;
          idx_d   = low_idx;
        end
      end
      StHaltReq: begin
        if (tmo_hit)                           state_d = StRstHold;
        else if (bus.dom_halt_ack_i[idx_q])    state_d = StHaltWait;
      end
      StHaltWait: begin
        if (tmo_hit || bus.dom_halt_status_i[idx_q]) state_d = StRstHold;
      end
      StRstHold: begin
        if (elapsed && bus.dom_rel_ok_i[idx_q]) state_d = StRun;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  assign boot_rel   = (state_q == StBootWait) && elapsed && bus.dom_go_i[idx_q];
  assign halt_entry = (state_q == StRun) && (state_d == StHaltReq);
  assign hold_entry = (state_q != StRstHold) && (state_d == StRstHold);
  assign hold_exit  = (state_q == StRstHold) && (state_d == StRun);
  assign cnt_clr    = ((state_q == StIdle) && (state_d == StBootWait)) || boot_rel || hold_entry;
  assign pend_clr   = halt_entry ? (NUM_DOM'(1) << idx_d) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      pending_q   <= '0;
      rst_b_q     <= '0;
      halt_req_q  <= '0;
      once_q      <= '0;
      tmo_q       <= '0;
      boot_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // A new request on the same edge as the clear keeps the domain pending.
      pending_q <= (pending_q & ~pend_clr) |
                   ((state_q != StIdle) ? bus.dom_rst_req_i : '0);
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (((state_q == StBootWait) || (state_q == StRstHold)) && !elapsed) begin
        cnt_q <= cnt_q + MIN_RST_CNT_W'(1);
      end
      if (halt_entry) begin
        tcnt_q <= '0;
      end else if (in_halt && !tmo_hit) begin
        tcnt_q <= tcnt_q + HALT_TMO_W'(1);
      end
      if (boot_rel) begin
        rst_b_q[idx_q] <= 1'b1;
        if (state_d == StRun) boot_done_q <= 1'b1;
      end
      if (halt_entry) halt_req_q[idx_d] <= 1'b1;
      if ((state_q == StHaltReq) && (state_d != StHaltReq)) halt_req_q[idx_q] <= 1'b0;
      if (tmo_hit) tmo_q[idx_q] <= 1'b1;
      if (hold_entry) begin
        rst_b_q[idx_q] <= 1'b0;
        once_q[idx_q]  <= 1'b1;
      end
      if (hold_exit) rst_b_q[idx_q] <= 1'b1;
    end
  end

  assign bus.dom_rst_b_o       = bus.scan_mode ? {NUM_DOM{~rst}} : rst_b_q;
  assign bus.dom_halt_req_o    = halt_req_q;
  assign bus.dom_rdc_clk_dis_o = ((state_q == StRstHold) || (state_d == StRstHold)) ?
                                 (NUM_DOM'(1) << idx_q) : '0;
  assign bus.dom_reset_once_o  = once_q;
  assign bus.dom_halt_tmo_o    = tmo_q;
  assign bus.boot_done_o       = boot_done_q;
  assign bus.busy_o            = (state_q != StIdle) && (state_q != StRun);

  state_legal: assert property (@(posedge clk) disable iff (rst) state_q <= StRstHold);
endmodule

// File: tb/tb_mci_multi_dom_rst_seqr.sv
// Bench for the multi-domain reset sequencer: expected behaviour is derived from event times
// (release edges, handshake edges, timeout edge) computed arithmetically per transaction.
module tb_mci_multi_dom_rst_seqr;
  localparam int N       = 4;
  localparam int HoldCyc = 16;
  localparam int TmoCyc  = 256;
  localparam int Big     = 1000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mci_multi_dom_rst_seqr_if #(.NUM_DOM(N)) bus ();

  mci_multi_dom_rst_seqr #(
    .NUM_DOM      (N),
    .MIN_RST_CNT_W(4),
    .HALT_TMO_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  int go_at [N];
  logic [N-1:0] m_pend, m_once, m_tmo;
  logic         m_done;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input logic [N-1:0] e_rst, input logic [N-1:0] e_hreq,
                           input logic [N-1:0] e_rdc, input logic e_busy);
    chk("rst_b", bus.dom_rst_b_o, e_rst);
    chk("halt_req", bus.dom_halt_req_o, e_hreq);
    chk("rdc_clk_dis", bus.dom_rdc_clk_dis_o, e_rdc);
    chk("reset_once", bus.dom_reset_once_o, m_once);
    chk("halt_tmo", bus.dom_halt_tmo_o, m_tmo);
    chk("boot_done", N'(bus.boot_done_o), N'(m_done));
    chk("busy", N'(bus.busy_o), N'(e_busy));
  endtask

  // Domain i is released at max(previous release + hold, first edge its go is seen).
  task automatic boot(input int req_k, input logic [N-1:0] req_mask);
    int rel [N];
    int s;
    logic [N-1:0] e_rst;
    s = 0;
    for (int i = 0; i < N; i++) begin
      rel[i] = (s + HoldCyc > go_at[i]) ? s + HoldCyc : go_at[i];
      s = rel[i];
    end
    bus.seq_go_i      = 1'b1;
    bus.dom_rst_req_i = '0;
    for (int i = 0; i < N; i++) bus.dom_go_i[i] = (go_at[i] <= 0);
    for (int k = 0; k <= rel[N-1]; k++) begin
      @(posedge clk);
      cyc = k;
      #1;
      if (k == req_k) m_pend |= req_mask;
      if (k >= rel[N-1]) m_done = 1'b1;
      bus.seq_go_i = 1'b0;
      for (int i = 0; i < N; i++) bus.dom_go_i[i] = (k + 1 >= go_at[i]);
      bus.dom_rst_req_i = (k + 1 == req_k) ? req_mask : '0;
      for (int i = 0; i < N; i++) e_rst[i] = (k >= rel[i]);
      @(negedge clk);
      check_all(e_rst, '0, '0, k < rel[N-1]);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      cyc++;
      #1;
      bus.dom_go_i          = N'($urandom);
      bus.dom_halt_ack_i    = N'($urandom);
      bus.dom_halt_status_i = N'($urandom);
      bus.dom_rel_ok_i      = N'($urandom);
      bus.dom_rst_req_i     = '0;
      @(negedge clk);
      check_all('1, '0, '0, 1'b0);
    end
  endtask

  task automatic request(input logic [N-1:0] mask);
    bus.dom_rst_req_i = mask;
    @(posedge clk);
    cyc++;
    #1;
    m_pend |= mask;
    bus.dom_rst_req_i = '0;
    @(negedge clk);
    check_all('1, '0, '0, 1'b0);
  endtask

  // Services the lowest pending domain; ack_lat/stat_lat >= Big mean never answered.
  task automatic serve(input int ack_lat, input int stat_lat, input int rel_lat,
                       input logic [N-1:0] inj_mask, input int stop_at);
    int d, h, a, b, sb, hend, e, rel_at, inj_k;
    bit to;
    logic [N-1:0] oh, e_rst, e_hreq, e_rdc;
    d = 0;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) d = i;
    oh    = N'(1) << d;
    h     = cyc + 1;
    a     = h + ack_lat;
    to    = 1'b0;
    sb    = Big;
    if (a >= h + TmoCyc) begin
      to = 1'b1; b = h + TmoCyc; hend = b;
    end else begin
      hend = a;
      sb   = a + stat_lat;
      if (sb >= h + TmoCyc) begin to = 1'b1; b = h + TmoCyc; end
      else b = sb;
    end
    rel_at = b + rel_lat;
    e      = (rel_at > b + HoldCyc) ? rel_at : b + HoldCyc;
    inj_k  = h + 2;
    for (int k = h; k <= e; k++) begin
      @(posedge clk);
      cyc = k;
      #1;
      if (k == h) m_pend[d] = 1'b0;
      if (k == inj_k) m_pend |= inj_mask;
      if (k >= b) begin
        m_once[d] = 1'b1;
        if (to) m_tmo[d] = 1'b1;
      end
      bus.dom_halt_ack_i    = (N'($urandom) & ~oh) | ((k + 1 >= a && k + 1 < b) ? oh : '0);
      bus.dom_halt_status_i = (N'($urandom) & ~oh) | ((k + 1 >= sb && k + 1 <= e) ? oh : '0);
      bus.dom_rel_ok_i      = (N'($urandom) & ~oh) | ((k + 1 >= rel_at) ? oh : '0);
      bus.dom_go_i          = N'($urandom);
      bus.dom_rst_req_i     = (k + 1 == inj_k) ? inj_mask : '0;
      e_rst  = ~((k >= b && k < e) ? oh : '0);
      e_hreq = (k < hend) ? oh : '0;
      e_rdc  = (k >= b - 1 && k < e) ? oh : '0;
      @(negedge clk);
      check_all(e_rst, e_hreq, e_rdc, k < e);
      if (k == stop_at) break;
    end
  endtask

  task automatic serve_all();
    while (m_pend != '0) begin
      serve($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(0, 30), '0, -1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    m_pend = '0; m_once = '0; m_tmo = '0; m_done = 1'b0;
    rst = 1'b1;
    bus.scan_mode = 1'b0; bus.seq_go_i = 1'b0; bus.dom_go_i = '0; bus.dom_rst_req_i = '0;
    bus.dom_halt_ack_i = '0; bus.dom_halt_status_i = '0; bus.dom_rel_ok_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all('0, '0, '0, 1'b0);
    bus.scan_mode = 1'b1;
    #1 chk("scan_in_rst", bus.dom_rst_b_o, '0);
    rst = 1'b0;
    #1 chk("scan_out_rst", bus.dom_rst_b_o, '1);
    bus.scan_mode = 1'b0;
    #1 chk("scan_off", bus.dom_rst_b_o, '0);

    // Requests in IDLE must be ignored.
    bus.dom_rst_req_i = '1;
    repeat (3) @(posedge clk);
    #1 bus.dom_rst_req_i = '0;
    @(negedge clk);
    check_all('0, '0, '0, 1'b0);

    // Boot with domain 1 held back; domain 3 requests reset during boot.
    go_at[0] = $urandom_range(0, 30);
    go_at[1] = 100 + $urandom_range(0, 20);
    go_at[2] = $urandom_range(0, 60);
    go_at[3] = $urandom_range(0, 90);
    boot(50, 4'b1000);
    serve_all();
    idle(10);

    // Two simultaneous requests: 1 before 2, with a re-request of 2 while it is serviced.
    request(4'b0110);
    serve($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(0, 30), '0, -1);
    serve($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(0, 30), 4'b0100, -1);
    serve_all();
    idle(5);

    // Halt ack never returned, and release held off for 50 cycles.
    request(4'b0001);
    serve(Big, 5, 50, '0, -1);
    idle(5);

    // Ack returned but halt status never reported.
    request(4'b1000);
    serve($urandom_range(1, 10), Big, $urandom_range(0, 30), '0, -1);
    idle(5);

    // Reset mid-handshake with another request pending, then a clean re-boot.
    request(4'b0100);
    serve(3, Big, 10, 4'b0001, cyc + 9);
    #2;
    rst = 1'b1;
    bus.seq_go_i = 1'b0;
    bus.dom_rst_req_i = '0;
    m_pend = '0; m_once = '0; m_tmo = '0; m_done = 1'b0;
    #1 check_all('0, '0, '0, 1'b0);
    @(posedge clk);
    #1 check_all('0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) go_at[i] = 0;
    boot(-5, '0);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
